// File: rtl/rob_update_arb_if.sv
// Completion writeback bus between the functional units and the ROB update arbiter.
// The master side drives source completions and branch_miss; the slave side is the arbiter.
interface rob_update_arb_if #(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned ROB_IDX = 5,
  parameter int unsigned BA_W    = 64,
  parameter int unsigned SRC_IDX = 2
);
  logic                       branch_miss;
  logic [N_SRC-1:0]           src_valid;
  logic [N_SRC-1:0]           src_ready;
  logic [N_SRC*ROB_IDX-1:0]   src_rob_idx;
  logic [N_SRC*BA_W-1:0]      src_ba;
  logic [N_SRC-1:0]           src_bt;
  logic                       up1_req;
  logic                       up2_req;
  logic [ROB_IDX-1:0]         rob_idx_out1;
  logic [ROB_IDX-1:0]         rob_idx_out2;
  logic [BA_W-1:0]            ba_ex_out1;
  logic [BA_W-1:0]            ba_ex_out2;
  logic                       bt_ex_out1;
  logic                       bt_ex_out2;
  logic [SRC_IDX:0]           pending;

  modport master (
    output branch_miss, src_valid, src_rob_idx, src_ba, src_bt,
    input  src_ready, up1_req, up2_req, rob_idx_out1, rob_idx_out2,
           ba_ex_out1, ba_ex_out2, bt_ex_out1, bt_ex_out2, pending
  );

  modport slave (
    input  branch_miss, src_valid, src_rob_idx, src_ba, src_bt,
    output src_ready, up1_req, up2_req, rob_idx_out1, rob_idx_out2,
           ba_ex_out1, ba_ex_out2, bt_ex_out1, bt_ex_out2, pending
  );
endinterface

// File: rtl/rob_update_arb.sv
// Round-robin arbiter folding N_SRC one-entry completion slots onto the ROB's
// two update ports; branch_miss flushes every held result.
module rob_update_arb #(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned ROB_IDX = 5,
  parameter int unsigned BA_W    = 64,
  parameter int unsigned SRC_IDX = 2
) (
  input  logic           clk,
  input  logic           reset,
  rob_update_arb_if.slave bus
);
  localparam int unsigned CNT_W = SRC_IDX + 1;

  logic [N_SRC-1:0]   r_full;
  logic [ROB_IDX-1:0] r_slot_idx [N_SRC];
  logic [BA_W-1:0]    r_slot_ba  [N_SRC];
  logic [N_SRC-1:0]   r_slot_bt;
  logic [SRC_IDX-1:0] r_rr_ptr;

  logic               r_up1_req;
  logic               r_up2_req;
  logic [ROB_IDX-1:0] r_rob_idx_out1;
  logic [ROB_IDX-1:0] r_rob_idx_out2;
  logic [BA_W-1:0]    r_ba_ex_out1;
  logic [BA_W-1:0]    r_ba_ex_out2;
  logic               r_bt_ex_out1;
  logic               r_bt_ex_out2;
  logic [CNT_W-1:0]   r_pending;

  logic [SRC_IDX-1:0] w_scan;
  logic [SRC_IDX-1:0] w_g1;
  logic [SRC_IDX-1:0] w_g2;
  logic               w_g1_vld;
  logic               w_g2_vld;
  logic [N_SRC-1:0]   w_grant;
  logic [N_SRC-1:0]   w_src_ready;
  logic [N_SRC-1:0]   w_accept;
  logic [N_SRC-1:0]   w_full_nxt;
  logic [CNT_W-1:0]   w_pend_cnt;

  // First two full slots in circular order starting at the round-robin pointer
  always_comb begin
    w_scan   = '0;
    w_g1     = '0;
    w_g2     = '0;
    w_g1_vld = 1'b0;
    w_g2_vld = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      w_scan = r_rr_ptr + SRC_IDX'(k);
      if (r_full[w_scan]) begin
        if (!w_g1_vld) begin
          w_g1_vld = 1'b1;
          w_g1     = w_scan;
        end else if (!w_g2_vld) begin
          w_g2_vld = 1'b1;
          w_g2     = w_scan;
        end
      end
    end
  end

  // A granted slot frees up this edge, so it may accept a replacement at once
  always_comb begin
    w_grant    = '0;
    w_pend_cnt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_grant[i] = (w_g1_vld && (w_g1 == SRC_IDX'(i))) ||
                   (w_g2_vld && (w_g2 == SRC_IDX'(i)));
    end
    w_src_ready = {N_SRC{!bus.branch_miss}} & (~r_full | w_grant);
    w_accept    = bus.src_valid & w_src_ready;
    w_full_nxt  = bus.branch_miss ? '0 : (w_accept | (r_full & ~w_grant));
    for (int i = 0; i < N_SRC; i++) begin
      w_pend_cnt = w_pend_cnt + CNT_W'(w_full_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full         <= '0;
      r_slot_bt      <= '0;
      r_rr_ptr       <= '0;
      r_up1_req      <= 1'b0;
      r_up2_req      <= 1'b0;
      r_rob_idx_out1 <= '0;
      r_rob_idx_out2 <= '0;
      r_ba_ex_out1   <= '0;
      r_ba_ex_out2   <= '0;
      r_bt_ex_out1   <= 1'b0;
      r_bt_ex_out2   <= 1'b0;
      r_pending      <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        r_slot_idx[i] <= '0;
        r_slot_ba[i]  <= '0;
      end
    end else begin
      r_full    <= w_full_nxt;
      r_pending <= w_pend_cnt;
      for (int i = 0; i < N_SRC; i++) begin
        if (w_accept[i]) begin
          r_slot_idx[i] <= bus.src_rob_idx[i*ROB_IDX +: ROB_IDX];
          r_slot_ba[i]  <= bus.src_ba[i*BA_W +: BA_W];
          r_slot_bt[i]  <= bus.src_bt[i];
        end
      end
      if (bus.branch_miss) begin
        r_up1_req <= 1'b0;
        r_up2_req <= 1'b0;
      end else begin
        r_up1_req <= w_g1_vld;
        r_up2_req <= w_g2_vld;
        if (w_g1_vld) begin
          r_rob_idx_out1 <= r_slot_idx[w_g1];
          r_ba_ex_out1   <= r_slot_ba[w_g1];
          r_bt_ex_out1   <= r_slot_bt[w_g1];
        end
        if (w_g2_vld) begin
          r_rob_idx_out2 <= r_slot_idx[w_g2];
          r_ba_ex_out2   <= r_slot_ba[w_g2];
          r_bt_ex_out2   <= r_slot_bt[w_g2];
        end
        // Pointer moves just past the last slot served
        if (w_g2_vld) begin
          r_rr_ptr <= w_g2 + SRC_IDX'(1);
        end else if (w_g1_vld) begin
          r_rr_ptr <= w_g1 + SRC_IDX'(1);
        end
      end
    end
  end

  assign bus.src_ready    = w_src_ready;
  assign bus.up1_req      = r_up1_req;
  assign bus.up2_req      = r_up2_req;
  assign bus.rob_idx_out1 = r_rob_idx_out1;
  assign bus.rob_idx_out2 = r_rob_idx_out2;
  assign bus.ba_ex_out1   = r_ba_ex_out1;
  assign bus.ba_ex_out2   = r_ba_ex_out2;
  assign bus.bt_ex_out1   = r_bt_ex_out1;
  assign bus.bt_ex_out2   = r_bt_ex_out2;
  assign bus.pending      = r_pending;
endmodule

// File: tb/tb_rob_update_arb.sv
// Directed bench for rob_update_arb: reset, single/quad completions, saturation,
// refill bypass and branch_miss flush with hand-computed expectations.
module tb_rob_update_arb;
  localparam int unsigned N_SRC   = 4;
  localparam int unsigned ROB_IDX = 5;
  localparam int unsigned BA_W    = 64;
  localparam int unsigned SRC_IDX = 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  rob_update_arb_if #(.N_SRC(N_SRC), .ROB_IDX(ROB_IDX), .BA_W(BA_W), .SRC_IDX(SRC_IDX)) bus ();

  rob_update_arb #(.N_SRC(N_SRC), .ROB_IDX(ROB_IDX), .BA_W(BA_W), .SRC_IDX(SRC_IDX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.src_valid   = '0;
    bus.src_rob_idx = '0;
    bus.src_ba      = '0;
    bus.src_bt      = '0;
  endtask

  task automatic set_src(input int i, input logic [4:0] idx, input logic [63:0] ba, input logic bt);
    bus.src_valid[i]              = 1'b1;
    bus.src_rob_idx[i*ROB_IDX +: ROB_IDX] = idx;
    bus.src_ba[i*BA_W +: BA_W]    = ba;
    bus.src_bt[i]                 = bt;
  endtask

  // Phase p presents idx 4p+i, ba p*256+i, bt (p+i) odd on every source
  task automatic drive_all(input int p);
    for (int i = 0; i < N_SRC; i++) begin
      set_src(i, 5'(4*p + i), 64'(p*256 + i), 1'((p + i) % 2));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.branch_miss = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_up1", 64'(bus.up1_req), 64'd0);
    chk("rst_pending", 64'(bus.pending), 64'd0);
    reset = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.src_ready), 64'hF);

    // Single completion on source 0
    set_src(0, 5'd7, 64'h100, 1'b1);
    tick();
    chk("single_acc_pending", 64'(bus.pending), 64'd1);
    chk("single_acc_up1", 64'(bus.up1_req), 64'd0);
    idle();
    tick();
    chk("single_up1", 64'(bus.up1_req), 64'd1);
    chk("single_idx1", 64'(bus.rob_idx_out1), 64'd7);
    chk("single_ba1", bus.ba_ex_out1, 64'h100);
    chk("single_bt1", 64'(bus.bt_ex_out1), 64'd1);
    chk("single_up2", 64'(bus.up2_req), 64'd0);
    chk("single_pending0", 64'(bus.pending), 64'd0);
    tick();
    chk("single_up1_drop", 64'(bus.up1_req), 64'd0);

    // Slots 0 and 2 with rr_ptr=1: slot 2 wins port 1, both refill
    set_src(0, 5'd10, 64'h10, 1'b0);
    set_src(2, 5'd11, 64'h11, 1'b1);
    tick();
    chk("fill02_pending", 64'(bus.pending), 64'd2);
    set_src(0, 5'd12, 64'h12, 1'b0);
    set_src(2, 5'd13, 64'h13, 1'b0);
    #1;
    chk("fill02_ready", 64'(bus.src_ready), 64'hF);
    tick();
    chk("fill02_up1", 64'(bus.up1_req), 64'd1);
    chk("fill02_up2", 64'(bus.up2_req), 64'd1);
    chk("fill02_idx1", 64'(bus.rob_idx_out1), 64'd11);
    chk("fill02_idx2", 64'(bus.rob_idx_out2), 64'd10);
    chk("fill02_pending2", 64'(bus.pending), 64'd2);

    // Asynchronous reset mid-traffic
    idle();
    reset = 1'b0;
    #1;
    chk("async_rst_up1", 64'(bus.up1_req), 64'd0);
    chk("async_rst_up2", 64'(bus.up2_req), 64'd0);
    chk("async_rst_pending", 64'(bus.pending), 64'd0);
    chk("async_rst_idx1", 64'(bus.rob_idx_out1), 64'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("async_rst_ready", 64'(bus.src_ready), 64'hF);

    // Four simultaneous completions, rr_ptr=0
    for (int i = 0; i < N_SRC; i++) set_src(i, 5'(3 + i), 64'(16*(i + 3)), 1'(i % 2));
    tick();
    chk("quad_pending4", 64'(bus.pending), 64'd4);
    idle();
    tick();
    chk("quadA_idx1", 64'(bus.rob_idx_out1), 64'd3);
    chk("quadA_idx2", 64'(bus.rob_idx_out2), 64'd4);
    chk("quadA_ba2", bus.ba_ex_out2, 64'h40);
    chk("quadA_bt2", 64'(bus.bt_ex_out2), 64'd1);
    chk("quadA_pending", 64'(bus.pending), 64'd2);
    chk("quadA_ready", 64'(bus.src_ready), 64'hF);
    tick();
    chk("quadB_up2", 64'(bus.up2_req), 64'd1);
    chk("quadB_idx1", 64'(bus.rob_idx_out1), 64'd5);
    chk("quadB_idx2", 64'(bus.rob_idx_out2), 64'd6);
    chk("quadB_pending", 64'(bus.pending), 64'd0);
    tick();
    chk("quad_idle_up1", 64'(bus.up1_req), 64'd0);
    chk("quad_idle_up2", 64'(bus.up2_req), 64'd0);
    chk("quad_hold_idx1", 64'(bus.rob_idx_out1), 64'd5);

    // Refill bypass on slot 1, rr_ptr=0
    set_src(1, 5'd8, 64'h80, 1'b0);
    tick();
    set_src(1, 5'd9, 64'h90, 1'b1);
    #1;
    chk("bypass_ready", 64'(bus.src_ready), 64'hF);
    tick();
    chk("bypass_up1", 64'(bus.up1_req), 64'd1);
    chk("bypass_idx1_old", 64'(bus.rob_idx_out1), 64'd8);
    chk("bypass_pending", 64'(bus.pending), 64'd1);
    idle();
    tick();
    chk("bypass_up1_next", 64'(bus.up1_req), 64'd1);
    chk("bypass_idx1_new", 64'(bus.rob_idx_out1), 64'd9);
    chk("bypass_bt1_new", 64'(bus.bt_ex_out1), 64'd1);
    chk("bypass_pending0", 64'(bus.pending), 64'd0);

    // Saturation, rr_ptr=2
    drive_all(1);
    tick();
    chk("sat_pending", 64'(bus.pending), 64'd4);
    drive_all(2);
    #1;
    chk("sat_ready_a", 64'(bus.src_ready), 64'hC);
    tick();
    chk("sat1_idx1", 64'(bus.rob_idx_out1), 64'd6);
    chk("sat1_idx2", 64'(bus.rob_idx_out2), 64'd7);
    chk("sat1_ba1", bus.ba_ex_out1, 64'h102);
    drive_all(3);
    #1;
    chk("sat_ready_b", 64'(bus.src_ready), 64'h3);
    tick();
    chk("sat2_idx1", 64'(bus.rob_idx_out1), 64'd4);
    chk("sat2_idx2", 64'(bus.rob_idx_out2), 64'd5);
    drive_all(4);
    #1;
    chk("sat_ready_c", 64'(bus.src_ready), 64'hC);
    tick();
    chk("sat3_up1", 64'(bus.up1_req), 64'd1);
    chk("sat3_up2", 64'(bus.up2_req), 64'd1);
    chk("sat3_idx1", 64'(bus.rob_idx_out1), 64'd10);
    chk("sat3_idx2", 64'(bus.rob_idx_out2), 64'd11);
    chk("sat3_pending", 64'(bus.pending), 64'd4);
    idle();
    tick();
    chk("drain1_idx1", 64'(bus.rob_idx_out1), 64'd12);
    chk("drain1_idx2", 64'(bus.rob_idx_out2), 64'd13);
    chk("drain1_pending", 64'(bus.pending), 64'd2);
    tick();
    chk("drain2_idx1", 64'(bus.rob_idx_out1), 64'd18);
    chk("drain2_idx2", 64'(bus.rob_idx_out2), 64'd19);
    chk("drain2_ba2", bus.ba_ex_out2, 64'h403);
    chk("drain2_pending", 64'(bus.pending), 64'd0);

    // Flush with slots 0,1,3 full, rr_ptr=0
    set_src(0, 5'd20, 64'h200, 1'b0);
    set_src(1, 5'd21, 64'h210, 1'b0);
    set_src(3, 5'd23, 64'h230, 1'b0);
    tick();
    chk("flush_pre_pending", 64'(bus.pending), 64'd3);
    idle();
    set_src(2, 5'd22, 64'h220, 1'b0);
    bus.branch_miss = 1'b1;
    #1;
    chk("flush_ready", 64'(bus.src_ready), 64'h0);
    tick();
    bus.branch_miss = 1'b0;
    idle();
    chk("flush_pending", 64'(bus.pending), 64'd0);
    chk("flush_up1", 64'(bus.up1_req), 64'd0);
    chk("flush_up2", 64'(bus.up2_req), 64'd0);
    #1;
    chk("flush_ready_after", 64'(bus.src_ready), 64'hF);
    set_src(1, 5'd25, 64'h250, 1'b1);
    set_src(3, 5'd27, 64'h270, 1'b0);
    tick();
    idle();
    tick();
    chk("post_flush_up1", 64'(bus.up1_req), 64'd1);
    chk("post_flush_idx1", 64'(bus.rob_idx_out1), 64'd25);
    chk("post_flush_idx2", 64'(bus.rob_idx_out2), 64'd27);
    chk("post_flush_pending", 64'(bus.pending), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
